// File: rtl/int_fp_converter.sv
// int_fp_converter: integer to floating-point converter, 2-stage valid/ready pipeline.
//
// Stage 1 takes sign/magnitude and finds the leading-one position. Stage 2 normalises,
// rounds (nearest-even or truncate, chosen per sample), detects overflow and packs the result.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   int_i       integer sample (two's complement when SIGNED != 0)
//   rnd_mode_i  0: round-nearest-even, 1: truncate toward zero
//   valid_i     int_i/rnd_mode_i valid
//   ready_o     converter can accept this cycle
//   fp_o        {sign, exp, frac} result
//   ovf_o       result saturated to infinity
//   inexact_o   result differs from the exact integer value
//   valid_o     fp_o/ovf_o/inexact_o valid
//   ready_i     downstream accepts this cycle
module int_fp_converter #(
    parameter int unsigned INT_WIDTH    = 16,
    parameter int unsigned SIGNED       = 1,
    parameter int unsigned EXP_WIDTH    = 5,
    parameter int unsigned FRAC_WIDTH   = 10,
    parameter int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [INT_WIDTH-1:0]    int_i,
    input  logic                    rnd_mode_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] fp_o,
    output logic                    ovf_o,
    output logic                    inexact_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int unsigned EXP_MAX = 2 ** EXP_WIDTH - 1;
    localparam int unsigned BIAS    = 2 ** (EXP_WIDTH - 1) - 1;
    localparam int unsigned PW      = $clog2(INT_WIDTH);
    // Wide enough for left shifts up to FRAC_WIDTH and the mantissa plus carry.
    localparam int unsigned WW      = INT_WIDTH + FRAC_WIDTH + 2;
    localparam int unsigned MW      = FRAC_WIDTH + 2;
    // Holds BIAS + largest leading-one index + carry without wrapping.
    localparam int unsigned EW      = EXP_WIDTH + PW + 2;

    localparam logic [EXP_WIDTH-1:0] EXP_CODE = EXP_WIDTH'(EXP_MAX);

    // ---------------- Stage 1 ----------------
    logic                 s1_v_q, s1_sign_q, s1_rne_q;
    logic [INT_WIDTH-1:0] s1_mag_q;
    logic [PW-1:0]        s1_p_q;

    logic                 sign_d;
    logic [INT_WIDTH-1:0] mag_d;
    logic [PW-1:0]        p_d;
    logic                 s1_ready, s2_ready;

    assign s2_ready = !valid_o || ready_i;
    assign s1_ready = !s1_v_q || s2_ready;
    assign ready_o  = s1_ready;

    always_comb begin
        sign_d = (SIGNED != 0) && int_i[INT_WIDTH-1];
        // Negating the most negative value wraps back onto itself, which is the correct
        // unsigned magnitude 2**(INT_WIDTH-1).
        mag_d  = sign_d ? (~int_i + 1'b1) : int_i;
        p_d    = '0;
        for (int i = 0; i < int'(INT_WIDTH); i++) begin
            if (mag_d[i]) p_d = PW'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_rne_q  <= 1'b0;
            s1_mag_q  <= '0;
            s1_p_q    <= '0;
        end else if (s1_ready) begin
            s1_v_q <= valid_i;
            if (valid_i) begin
                s1_sign_q <= sign_d;
                s1_rne_q  <= !rnd_mode_i;
                s1_mag_q  <= mag_d;
                s1_p_q    <= p_d;
            end
        end
    end

    // ---------------- Stage 2 ----------------
    logic [WW-1:0]           ext, mask;
    logic [MW-1:0]           m_base, m_r;
    logic [FRAC_WIDTH-1:0]   frac;
    logic [EW-1:0]           e;
    logic                    guard, sticky, inc, carry;
    int unsigned             p_int, sh;
    logic [FP_WIDTH_REG-1:0] fp_d;
    logic                    ovf_d, inexact_d;
    logic                    unused_hidden;

    always_comb begin
        ext    = WW'(s1_mag_q);
        p_int  = int'(s1_p_q);
        sh     = 0;
        mask   = '0;
        m_base = '0;
        m_r    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        inc    = 1'b0;
        carry  = 1'b0;
        frac   = '0;
        if (p_int <= FRAC_WIDTH) begin
            frac = FRAC_WIDTH'(ext << (FRAC_WIDTH - p_int));
        end else begin
            sh     = p_int - FRAC_WIDTH;
            m_base = MW'(ext >> sh);
            guard  = 1'(ext >> (sh - 1));
            mask   = (WW'(1) << (sh - 1)) - WW'(1);
            sticky = |(ext & mask);
            inc    = s1_rne_q && guard && (sticky || m_base[0]);
            m_r    = m_base + MW'(inc);
            carry  = m_r[FRAC_WIDTH+1];
            frac   = carry ? '0 : m_r[FRAC_WIDTH-1:0];
        end
        e = EW'(BIAS) + EW'(s1_p_q) + EW'(carry);

        if (s1_mag_q == '0) begin
            fp_d      = '0;
            ovf_d     = 1'b0;
            inexact_d = 1'b0;
        end else if (e >= EW'(EXP_MAX)) begin
            fp_d      = {s1_sign_q, EXP_CODE, {FRAC_WIDTH{1'b0}}};
            ovf_d     = 1'b1;
            inexact_d = 1'b1;
        end else begin
            fp_d      = {s1_sign_q, e[EXP_WIDTH-1:0], frac};
            ovf_d     = 1'b0;
            inexact_d = guard || sticky;
        end
    end

    // Hidden bit is implied by the exponent and not stored.
    assign unused_hidden = m_r[FRAC_WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            fp_o      <= '0;
            ovf_o     <= 1'b0;
            inexact_o <= 1'b0;
        end else if (s2_ready) begin
            valid_o <= s1_v_q;
            if (s1_v_q) begin
                fp_o      <= fp_d;
                ovf_o     <= ovf_d;
                inexact_o <= inexact_d;
            end
        end
    end

endmodule

// File: tb/tb_int_fp_converter.sv
`timescale 1ns/1ps
module tb_int_fp_converter;

    logic        clk, rst_n;
    logic [15:0] int_i;
    logic        rnd, valid_i, ready_i;
    logic        ready_o, ovf_o, inex_o, valid_o;
    logic [15:0] fp_o;
    logic        u_ready_o, u_ovf_o, u_inex_o, u_valid_o;
    logic [15:0] u_fp_o;

    int n_checks = 0;
    int n_fail   = 0;

    int_fp_converter #(.INT_WIDTH(16), .SIGNED(1), .EXP_WIDTH(5), .FRAC_WIDTH(10)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .int_i(int_i), .rnd_mode_i(rnd), .valid_i(valid_i),
        .ready_o(ready_o), .fp_o(fp_o), .ovf_o(ovf_o), .inexact_o(inex_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    int_fp_converter #(.INT_WIDTH(16), .SIGNED(0), .EXP_WIDTH(5), .FRAC_WIDTH(10)) dut_u (
        .clk_i(clk), .rst_ni(rst_n), .int_i(int_i), .rnd_mode_i(rnd), .valid_i(valid_i),
        .ready_o(u_ready_o), .fp_o(u_fp_o), .ovf_o(u_ovf_o), .inexact_o(u_inex_o),
        .valid_o(u_valid_o), .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task test_reset;
        rst_n = 1'b1; int_i = '0; rnd = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || fp_o !== 16'h0 || ovf_o !== 1'b0 || inex_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b fp=%h ovf=%b inexact=%b, want 0 0000 0 0",
                     valid_o, fp_o, ovf_o, inex_o);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got ready_o=%b, want 1", ready_o);
        end
    endtask

    task test_basic;
        logic [15:0] v [4];
        logic [15:0] ef [4];
        v  = '{16'd1, 16'hFFFF, 16'd0, 16'h8000};
        ef = '{16'h3C00, 16'hBC00, 16'h0000, 16'hF800};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            int_i = v[i]; rnd = 1'b0; valid_i = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_latency_early[%0d]: got valid_o=%b, want 0", i, valid_o);
            end
            @(posedge clk); #1;
            n_checks++;
            if (valid_o !== 1'b1 || fp_o !== ef[i] || ovf_o !== 1'b0 || inex_o !== 1'b0) begin
                n_fail++;
                $display("FAIL basic[%0d] in=%h: got valid=%b fp=%h ovf=%b inexact=%b, want 1 %h 0 0",
                         i, v[i], valid_o, fp_o, ovf_o, inex_o, ef[i]);
            end
        end
    endtask

    task test_rounding;
        logic [15:0] v [5];
        logic        r [5];
        logic [15:0] ef [5];
        logic        ei [5];
        v  = '{16'd2049, 16'd2051, 16'd2051, 16'd32767, 16'd32767};
        r  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ef = '{16'h6800, 16'h6802, 16'h6801, 16'h7800, 16'h77FF};
        ei = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            int_i = v[i]; rnd = r[i]; valid_i = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (valid_o !== 1'b1 || fp_o !== ef[i] || ovf_o !== 1'b0 || inex_o !== ei[i]) begin
                n_fail++;
                $display("FAIL rounding[%0d] in=%0d rnd=%b: got valid=%b fp=%h ovf=%b inexact=%b, want 1 %h 0 %b",
                         i, v[i], r[i], valid_o, fp_o, ovf_o, inex_o, ef[i], ei[i]);
            end
        end
    endtask

    task test_unsigned;
        logic [15:0] v [3];
        logic        r [3];
        logic [15:0] ef [3];
        logic        eo [3];
        logic        ei [3];
        v  = '{16'd65535, 16'd65535, 16'd2048};
        r  = '{1'b0, 1'b1, 1'b0};
        ef = '{16'h7C00, 16'h7BFF, 16'h6800};
        eo = '{1'b1, 1'b0, 1'b0};
        ei = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            int_i = v[i]; rnd = r[i]; valid_i = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (u_valid_o !== 1'b1 || u_fp_o !== ef[i] || u_ovf_o !== eo[i] || u_inex_o !== ei[i]) begin
                n_fail++;
                $display("FAIL unsigned[%0d] in=%0d rnd=%b: got valid=%b fp=%h ovf=%b inexact=%b, want 1 %h %b %b",
                         i, v[i], r[i], u_valid_o, u_fp_o, u_ovf_o, u_inex_o, ef[i], eo[i], ei[i]);
            end
        end
    endtask

    task test_back_to_back;
        logic [15:0] exp_seq [20];
        int          in_idx, out_idx, occ;
        logic        in_fire, out_fire, stalled, exp_rdy;
        logic [15:0] prev_fp;
        exp_seq = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700,
                    16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00,
                    16'h4B80, 16'h4C00, 16'h4C40, 16'h4C80, 16'h4CC0, 16'h4D00};
        in_idx = 0; out_idx = 0; occ = 0;
        valid_i = 1'b0; ready_i = 1'b1; rnd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 400 && out_idx < 20; cyc++) begin
            valid_i = (in_idx < 20);
            int_i   = 16'(in_idx + 1);
            ready_i = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = !(occ == 2 && !ready_i);
            n_checks++;
            if (ready_o !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_ready_o cyc=%0d occ=%0d: got %b, want %b", cyc, occ, ready_o, exp_rdy);
            end
            in_fire  = valid_i && ready_o;
            out_fire = valid_o && ready_i;
            stalled  = valid_o && !ready_i;
            prev_fp  = fp_o;
            if (out_fire) begin
                n_checks++;
                if (fp_o !== exp_seq[out_idx]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got fp=%h, want %h", out_idx, fp_o, exp_seq[out_idx]);
                end
                out_idx++;
            end
            @(posedge clk); #1;
            if (in_fire) in_idx++;
            occ = occ + int'(in_fire) - int'(out_fire);
            if (stalled) begin
                n_checks++;
                if (valid_o !== 1'b1 || fp_o !== prev_fp) begin
                    n_fail++;
                    $display("FAIL b2b_stall_hold: got valid=%b fp=%h, want 1 %h", valid_o, fp_o, prev_fp);
                end
            end
        end
        n_checks++;
        if (out_idx != 20) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs within cycle budget, want 20", out_idx);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_extra_output: got valid_o=%b fp=%h, want valid_o=0", valid_o, fp_o);
            end
        end
    endtask

    task test_reset_mid;
        ready_i = 1'b1; rnd = 1'b0;
        @(posedge clk); #1;
        int_i = 16'd5; valid_i = 1'b1;
        @(posedge clk); #1;
        int_i = 16'd6;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || fp_o !== 16'h4500) begin
            n_fail++;
            $display("FAIL reset_mid_inflight: got valid=%b fp=%h, want 1 4500", valid_o, fp_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || fp_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got valid=%b fp=%h, want 0 0000", valid_o, fp_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_stale: got valid=%b ready_o=%b, want 0 1", valid_o, ready_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_unsigned();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
